// File: rtl/message_sequencer.sv
`timescale 1ns/1ps
// Writable message store with a tick-driven playback engine feeding the
// downstream character decoder: one character per tick, one-shot or looping.
module message_sequencer #(
    parameter int unsigned  CHAR_W  = 4,
    parameter int unsigned  MAX_LEN = 16,
    parameter int unsigned  NUM_MSG = 4,
    localparam int unsigned ADDR_W  = $clog2(MAX_LEN),
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    localparam int unsigned SEL_W   = $clog2(NUM_MSG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_msg,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic              len_we,
    input  logic [LEN_W-1:0]  len_data,
    input  logic              start,
    input  logic [SEL_W-1:0]  msg_sel,
    input  logic              loop_mode,
    input  logic              tick,
    input  logic              abort,
    output logic [CHAR_W-1:0] caracter,
    output logic              caracter_valid,
    output logic [ADDR_W-1:0] counter_caracter,
    output logic [LEN_W-1:0]  len_string,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    typedef enum logic {ST_IDLE, ST_PLAY} state_e;

    state_e state_q, state_d;

    logic [CHAR_W-1:0] mem_q [NUM_MSG][MAX_LEN];
    logic [LEN_W-1:0]  len_q [NUM_MSG];

    logic [CHAR_W-1:0] char_q, char_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0]  slen_q, slen_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              loop_q, loop_d;

    logic [LEN_W-1:0]  start_len_c;
    logic [LEN_W-1:0]  len_clip_c;
    logic [ADDR_W-1:0] idx_inc_c;
    logic              last_c;
    logic              wr_ok_c;
    logic              len_ok_c;

    assign start_len_c = len_q[msg_sel];
    assign len_clip_c  = (32'(len_data) > MAX_LEN) ? LEN_W'(MAX_LEN) : len_data;
    assign idx_inc_c   = idx_q + ADDR_W'(1);
    assign last_c      = (LEN_W'(idx_q) == (slen_q - LEN_W'(1)));
    assign wr_ok_c     = wr_en && (32'(wr_addr) < MAX_LEN) && (32'(wr_msg) < NUM_MSG);
    assign len_ok_c    = len_we && (32'(wr_msg) < NUM_MSG);

    // Character memory: write port only, no reset
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wr_msg][wr_addr] <= wr_data;
        end
    end

    // Per-message lengths, clipped to MAX_LEN on write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_MSG; i++) begin
                len_q[i] <= '0;
            end
        end else if (len_ok_c) begin
            len_q[wr_msg] <= len_clip_c;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && (start_len_c != '0)) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (tick && last_c && !loop_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values; abort wins over tick
    always_comb begin
        char_d  = char_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        slen_d  = slen_q;
        sel_d   = sel_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_len_c == '0) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d   = msg_sel;
                        loop_d  = loop_mode;
                        slen_d  = start_len_c;
                        idx_d   = '0;
                        char_d  = mem_q[msg_sel][0];
                        valid_d = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (abort) begin
                    valid_d = 1'b0;
                end else if (tick) begin
                    if (!last_c) begin
                        idx_d  = idx_inc_c;
                        char_d = mem_q[sel_q][idx_inc_c];
                    end else if (loop_q) begin
                        idx_d  = '0;
                        char_d = mem_q[sel_q][0];
                        wrap_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        valid_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        busy_d = (state_d == ST_PLAY);
    end

    // Registered outputs and playback context
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            char_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            slen_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            sel_q   <= '0;
            loop_q  <= 1'b0;
        end else begin
            char_q  <= char_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            slen_q  <= slen_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            sel_q   <= sel_d;
            loop_q  <= loop_d;
        end
    end

    assign caracter         = char_q;
    assign caracter_valid   = valid_q;
    assign counter_caracter = idx_q;
    assign len_string       = slen_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign wrap             = wrap_q;

endmodule

// File: tb/tb_message_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for message_sequencer: a behavioural model predicts the
// output snapshot after every clock edge; a monitor compares after each edge.
module tb_message_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_msg = '0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic       len_we = 1'b0;
    logic [4:0] len_data = '0;
    logic       start = 1'b0;
    logic [1:0] msg_sel = '0;
    logic       loop_mode = 1'b0;
    logic       tick = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] caracter;
    logic       caracter_valid;
    logic [3:0] counter_caracter;
    logic [4:0] len_string;
    logic       busy;
    logic       done;
    logic       wrap;

    message_sequencer #(.CHAR_W(4), .MAX_LEN(16), .NUM_MSG(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_msg(wr_msg), .wr_addr(wr_addr), .wr_data(wr_data),
        .len_we(len_we), .len_data(len_data),
        .start(start), .msg_sel(msg_sel), .loop_mode(loop_mode),
        .tick(tick), .abort(abort),
        .caracter(caracter), .caracter_valid(caracter_valid),
        .counter_caracter(counter_caracter), .len_string(len_string),
        .busy(busy), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] chr;
        logic       valid;
        logic [3:0] idx;
        logic [4:0] len;
        logic       busy;
        logic       done;
        logic       wrap;
    } snap_t;

    snap_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    // Reference model state
    logic [3:0] m_mem [4][16];
    int         m_len [4];
    bit         m_play = 0;
    bit         m_loop = 0;
    int         m_sel = 0;
    int         m_slen = 0;
    int         m_idx = 0;
    logic [3:0] m_chr = '0;

    // Pending writes applied on the next cycle
    logic       pw_en = 1'b0;
    logic [1:0] pw_msg = '0;
    logic [3:0] pw_addr = '0;
    logic [3:0] pw_data = '0;
    logic       pl_we = 1'b0;
    logic [4:0] pl_data = '0;

    int codes [9] = '{9, 3, 5, 3, 4, 10, 0, 2, 7};

    // Predict the outcome of the coming clock edge from the current inputs
    task automatic model_edge();
        snap_t e;
        bit d = 0;
        bit w = 0;
        if (!reset_n) begin
            m_play = 0; m_loop = 0; m_sel = 0; m_slen = 0; m_idx = 0; m_chr = '0;
            for (int i = 0; i < 4; i++) m_len[i] = 0;
        end else begin
            if (!m_play) begin
                if (start) begin
                    if (m_len[msg_sel] == 0) begin
                        d = 1;
                    end else begin
                        m_play = 1;
                        m_sel  = int'(msg_sel);
                        m_loop = loop_mode;
                        m_slen = m_len[msg_sel];
                        m_idx  = 0;
                        m_chr  = m_mem[m_sel][0];
                    end
                end
            end else if (abort) begin
                m_play = 0;
            end else if (tick) begin
                if (m_idx + 1 < m_slen) begin
                    m_idx = m_idx + 1;
                    m_chr = m_mem[m_sel][m_idx];
                end else if (m_loop) begin
                    m_idx = 0;
                    m_chr = m_mem[m_sel][0];
                    w = 1;
                end else begin
                    m_play = 0;
                    d = 1;
                end
            end
            if (len_we) m_len[wr_msg] = (int'(len_data) > 16) ? 16 : int'(len_data);
        end
        if (wr_en) m_mem[wr_msg][wr_addr] = wr_data;
        e.chr   = m_chr;
        e.valid = m_play;
        e.idx   = 4'(m_idx);
        e.len   = 5'(m_slen);
        e.busy  = m_play;
        e.done  = d;
        e.wrap  = w;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic t, input logic a, input logic s,
                       input logic [1:0] ms, input logic lm);
        @(negedge clk);
        tick = t; abort = a; start = s; msg_sel = ms; loop_mode = lm;
        wr_en = pw_en; wr_msg = pw_msg; wr_addr = pw_addr; wr_data = pw_data;
        len_we = pl_we; len_data = pl_data;
        pw_en = 1'b0; pl_we = 1'b0;
        model_edge();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic tick3(input int n);
        for (int i = 0; i < n; i++) begin
            idle(2);
            cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        end
    endtask

    // Monitor: one expected snapshot per clock edge
    initial begin
        snap_t e;
        snap_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {caracter, caracter_valid, counter_caracter, len_string, busy, done, wrap};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got chr=%h v=%b idx=%0d len=%0d busy=%b done=%b wrap=%b exp chr=%h v=%b idx=%0d len=%0d busy=%b done=%b wrap=%b",
                             $time, a.chr, a.valid, a.idx, a.len, a.busy, a.done, a.wrap,
                             e.chr, e.valid, e.idx, e.len, e.busy, e.done, e.wrap);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) m_len[i] = 0;
        // Reset state
        idle(3);
        @(posedge clk); #2 reset_n = 1'b1;

        // Load all memory; lengths written alongside the first character
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < 16; a++) begin
                pw_en = 1'b1; pw_msg = 2'(m); pw_addr = 4'(a);
                pw_data = (m == 1 && a < 9) ? 4'(codes[a]) : 4'($urandom_range(0, 15));
                if (a == 0) begin
                    pl_we = 1'b1;
                    pl_data = (m == 0) ? 5'd5 : (m == 1) ? 5'd9 : (m == 2) ? 5'd0 : 5'd20;
                end
                idle(1);
            end
        end

        // One-shot playback of msg1, tick every third cycle
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        tick3(9);
        idle(3);

        // Looping playback, 20 ticks, then abort
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        tick3(20);
        cyc(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(2);

        // Zero-length message
        cyc(1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
        idle(2);

        // Abort together with tick at index 4
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        tick3(4);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        idle(2);

        // Length and character rewrite during playback; start with abort high
        cyc(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        tick3(2);
        pw_en = 1'b1; pw_msg = 2'd1; pw_addr = 4'd6; pw_data = 4'd15;
        pl_we = 1'b1; pl_data = 5'd3;
        cyc(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        tick3(6);
        idle(2);
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        tick3(3);
        idle(2);

        // Asynchronous reset mid-playback
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        tick3(1);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        checks++;
        if ({caracter, caracter_valid, counter_caracter, len_string, busy, done, wrap} !== 17'd0) begin
            errors++;
            $display("FAIL async_reset got chr=%h v=%b idx=%0d len=%0d busy=%b exp all zero",
                     caracter, caracter_valid, counter_caracter, len_string, busy);
        end
        idle(2);
        @(posedge clk); #2 reset_n = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b0);
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            pw_msg = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) begin
                pw_en = 1'b1;
                pw_addr = 4'($urandom_range(0, 15));
                pw_data = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 14) == 0) begin
                pl_we = 1'b1;
                pl_data = 5'($urandom_range(0, 20));
            end
            cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 29) == 0),
                1'($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
        end

        idle(2);
        @(posedge clk); #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending snapshots exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/message_sequencer.md
Name: message_sequencer

Overview:
- Parametrised, writable message store plus playback engine for the display path.
- Replaces the fixed, combinational per-word character ROMs: holds NUM_MSG messages of up to MAX_LEN characters, each CHAR_W bits.
- On request, steps through the selected message one character per tick, in either one-shot or loop mode.
- Presents the current character code, its index and the length to the downstream character decoder/driver.

Parameters:
- CHAR_W, 4, width of one character code.
- MAX_LEN, 16, maximum characters per message (>=2).
- NUM_MSG, 4, number of stored messages (>=2).
- Derived, not overridable: ADDR_W = clog2(MAX_LEN); LEN_W = clog2(MAX_LEN+1); SEL_W = clog2(NUM_MSG).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write one character to memory.
- wr_msg  in  SEL_W  message index for the character write.
- wr_addr  in  ADDR_W  character position for the write.
- wr_data  in  CHAR_W  character code to write.
- len_we  in  1  write the message length.
- len_data  in  LEN_W  new length for message wr_msg.
- start  in  1  request playback.
- msg_sel  in  SEL_W  message to play; sampled with start.
- loop_mode  in  1  1 = wrap at end; 0 = one-shot; sampled with start.
- tick  in  1  advance-one-character strobe (e.g. from a prescaler).
- abort  in  1  stop playback.
- caracter  out  CHAR_W  current character code (registered).
- caracter_valid  out  1  caracter is meaningful.
- counter_caracter  out  ADDR_W  index of the current character.
- len_string  out  LEN_W  length latched for the active playback.
- busy  out  1  high while in PLAY.
- done  out  1  one-cycle pulse at end of one-shot playback or zero-length start.
- wrap  out  1  one-cycle pulse when loop mode returns to index 0.

Behaviour:
Clocking and reset
- One clock. Reset is asynchronous and active-low, port reset_n.
- While reset_n=0: state IDLE; all outputs 0; all length registers 0.
- Character memory is not reset; its contents are undefined until written.
- Reset asserted mid-playback: immediate return to IDLE, busy=0, no done pulse.

Writes (accepted in any state)
- wr_en writes mem[wr_msg][wr_addr] at the edge.
- wr_addr >= MAX_LEN: write ignored (only reachable when MAX_LEN is not a power of two).
- len_we stores min(len_data, MAX_LEN) into len[wr_msg].
- wr_en and len_we may be asserted in the same cycle.
- A character write to the playing message is visible from the next caracter update onward.
- A length write does not affect an active playback; the length is snapshotted at start.

State machine: IDLE, PLAY
- IDLE, start=1, len[msg_sel]=0: stay IDLE; done=1 for the next cycle; busy stays 0.
- IDLE, start=1, len[msg_sel]>0, at edge E:
  - latch sel, loop_mode and len_string=len[msg_sel];
  - counter_caracter=0, caracter=mem[sel][0], caracter_valid=1, busy=1;
  - all visible in the cycle after E (1-cycle latency).
- IDLE: tick and abort are ignored. If start and abort are both high, start proceeds.
- PLAY, tick=1, index < len_string-1: index increments; caracter=mem[sel][index+1] after the edge.
- PLAY, tick=1, index = len_string-1, loop mode:
  - index=0, caracter=mem[sel][0], wrap=1 for one cycle;
  - remain in PLAY.
- PLAY, tick=1, index = len_string-1, one-shot:
  - go to IDLE, done=1 for one cycle;
  - busy=0, caracter_valid=0;
  - caracter, counter_caracter and len_string hold their last values.
- len_string=1 in loop mode: every tick pulses wrap; index stays 0.
- PLAY, abort=1: go to IDLE at the edge, busy=0, caracter_valid=0, no done pulse. abort has priority over tick.
- PLAY, start=1: ignored.
- done and wrap are never high in the same cycle.

Test Plan:
- Load msg1 with codes 9,3,5,3,4,10,0,2,7 and len=9; start msg_sel=1, loop=0; tick every 3rd cycle -> caracter 9,3,5,3,4,10,0,2,7 with counter_caracter 0..8; exactly 1 done pulse after the 9th tick; busy 1->0.
- Same message with loop=1 and 20 ticks -> wrap pulses after ticks 9 and 18; sequence restarts at 9; counter_caracter returns to 0 after each wrap; busy stays 1.
- len=0 for msg2, start msg_sel=2 -> done pulse the next cycle; busy and caracter_valid stay 0.
- Mid-playback (index 4): assert abort together with tick -> IDLE, no done pulse, caracter_valid=0; index does not advance.
- During playback of msg1: write len[1]=3 and mem[1][6]=15 -> playback still runs 9 characters; index 6 outputs 15. A later restart runs 3 characters (9,3,5).
- Drop reset_n asynchronously mid-PLAY, between clock edges -> outputs go 0 immediately; after release, start on msg1 -> no playback, done pulse (length was reset to 0).
